mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Shares one native picorv32-style memory port (valid/ready, 32-bit addr/wdata/rdata, 4-bit wstrb) between NUM_REQ requesters.
- Typical requesters: multiple cores, or a core plus a DMA/test master. Sits upstream of the native-to-AXI adapter and the memory model.
- Round-robin, one outstanding transaction, with a per-transaction timeout that force-completes a hung access and flags it.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 1024, max BUSY cycles before forced completion; 0 disables timeout
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on forced completion

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  reset, asynchronous assert, active-low
req_valid  input  NUM_REQ  per-requester request valid, held until its req_ready
req_instr  input  NUM_REQ  per-requester instruction-fetch flag
req_addr  input  32*NUM_REQ  packed addresses, requester i at [32i+31:32i]
req_wdata  input  32*NUM_REQ  packed write data
req_wstrb  input  4*NUM_REQ  packed byte strobes, 0 = read
req_ready  output  NUM_REQ  one-hot completion pulse to granted requester
req_rdata  output  32  read data, shared, valid when any req_ready bit is 1
mem_valid  output  1  downstream request valid
mem_instr  output  1  downstream instruction flag
mem_addr  output  32  downstream address
mem_wdata  output  32  downstream write data
mem_wstrb  output  4  downstream byte strobes
mem_ready  input  1  downstream completion, same cycle as mem_rdata
mem_rdata  input  32  downstream read data
timeout_err  output  1  one-cycle pulse on forced completion
timeout_id  output  3  requester index of last timeout, held until next timeout

Behaviour:
- Reset (resetn=0, async): state IDLE; mem_valid=0; mem_instr/addr/wdata/wstrb=0; req_ready=0; timeout_err=0; timeout_id=0; last_grant=NUM_REQ-1 so port 0 wins first; counter=0. Reset mid-transaction drops mem_valid immediately; no completion is reported.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid is set, grant the first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register grant index plus that requester's instr/addr/wdata/wstrb into the mem_* registers.
  - Set mem_valid=1 and go to BUSY. Arbitration latency is 1 cycle from req_valid to mem_valid.
- BUSY:
  - mem_valid and mem_* are held stable; upstream changes are ignored.
  - req_ready[grant] = mem_ready (combinational). req_rdata = mem_rdata (combinational).
  - On mem_ready=1: next edge sets mem_valid=0, last_grant=grant, state IDLE, counter=0.
  - Minimum gap between back-to-back downstream requests is 1 idle cycle. Throughput is 1 transaction per (downstream latency + 2) cycles.
- Timeout (TIMEOUT>0):
  - counter increments each BUSY cycle without mem_ready.
  - When counter==TIMEOUT-1 and mem_ready=0, that cycle: req_ready[grant]=1, req_rdata=TIMEOUT_RDATA, timeout_err=1.
  - Next edge: timeout_id=grant, mem_valid=0, state IDLE, last_grant=grant.
  - mem_ready arriving on the expiry cycle takes precedence: normal completion, no error.
- req_ready is all-zero in IDLE. Never more than one bit set.
- A requester dropping req_valid while granted is a protocol violation. The transaction still completes and req_ready still pulses.
- Non-granted requesters wait with no starvation: worst-case wait is NUM_REQ-1 transactions.
- mem_wstrb=0 means read. The arbiter does not interpret addresses.

Test Plan:
1. Single read: req_valid=2'b01, addr0=0x100, wstrb0=0; memory returns 0x1234_5678 after 3 cycles -> mem_valid 1 cycle after req_valid, mem_addr=0x100, req_ready=2'b01 for one cycle with req_rdata=0x1234_5678.
2. Contention: both valid from cycle 0, each held until ready, 2 transactions each -> downstream grant order 0,1,0,1; mem_addr/wdata match the granted port each time.
3. Write passthrough: requester 1 writes addr 0x2000_0000, wdata=123456789, wstrb=4'hF -> mem_* carry exactly these values; req_ready=2'b10.
4. Timeout: TIMEOUT=16, mem_ready tied 0, requester 0 reads -> req_ready[0] and timeout_err pulse on the 16th BUSY cycle, req_rdata=0xDEAD_BEEF, timeout_id=0, mem_valid low next cycle.
5. Race at expiry: mem_ready asserted exactly on cycle TIMEOUT-1 -> normal completion with mem_rdata, timeout_err stays 0.
6. Reset mid-BUSY: resetn low while mem_valid=1 -> mem_valid=0 without waiting for a clock edge. After release, a pending request on port 1 only is granted to port 1.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Shares one native valid/ready memory port between NUM_REQ requesters.
//   Round-robin arbitration, one outstanding transaction, and an optional
//   per-transaction timeout that force-completes a hung access.
//
// Ports
//   clk, resetn          clock (rising edge), async active-low reset
//   req_valid/instr      per-requester request valid and fetch flag
//   req_addr/wdata       packed 32-bit fields, requester i at [32i+31:32i]
//   req_wstrb            packed 4-bit byte strobes, 0 = read
//   req_ready            one-hot completion pulse to the granted requester
//   req_rdata            shared read data, valid with any req_ready bit
//   mem_*                downstream native port (registered request side)
//   mem_ready/mem_rdata  downstream completion and read data
//   timeout_err          one-cycle pulse on a forced completion
//   timeout_id           requester index of the most recent timeout

// Per-requester completion decode.
module mem_rr_arbiter_lane #(
  parameter int LANE = 0
) (
  input  logic [2:0] grant,
  input  logic       done,
  output logic       ready
);
  assign ready = done && (grant == 3'(LANE));
endmodule

module mem_rr_arbiter #(
  parameter int          NUM_REQ       = 2,
  parameter int          TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_instr,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0] req_wdata,
  input  logic [4*NUM_REQ-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [31:0]          req_rdata,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic                 timeout_err,
  output logic [2:0]           timeout_id
);
  localparam int          CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]  NR4 = 4'(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [2:0]      last_grant, grant;
  logic [CW-1:0]   counter;

  // Fields spread into fixed 8-entry tables so a 3-bit index selects
  // exactly; unused entries read as zero.
  logic [7:0]      instr_a;
  logic [31:0]     addr_a  [8];
  logic [31:0]     wdata_a [8];
  logic [3:0]      wstrb_a [8];

  for (genvar i = 0; i < 8; i++) begin : g_tab
    if (i < NUM_REQ) begin : g_used
      assign instr_a[i] = req_instr[i];
      assign addr_a[i]  = req_addr[32*i +: 32];
      assign wdata_a[i] = req_wdata[32*i +: 32];
      assign wstrb_a[i] = req_wstrb[4*i +: 4];
    end else begin : g_pad
      assign instr_a[i] = 1'b0;
      assign addr_a[i]  = '0;
      assign wdata_a[i] = '0;
      assign wstrb_a[i] = '0;
    end
  end

  // Round-robin pick: rotate the request vector so bit 0 is the requester
  // right after last_grant, find the lowest set bit, then un-rotate.
  logic [3:0]         shamt, sum, sum_m;
  logic [NUM_REQ-1:0] rot;
  logic [2:0]         off, pick;
  logic               pick_vld;

  assign shamt = {1'b0, last_grant} + 4'd1;
  assign rot   = NUM_REQ'({req_valid, req_valid} >> shamt);

  always_comb begin
    off      = '0;
    pick_vld = |rot;
    for (int j = NUM_REQ-1; j >= 0; j--)
      if (rot[j]) off = 3'(j);
  end

  assign sum   = {1'b0, last_grant} + {1'b0, off} + 4'd1;
  assign sum_m = (sum >= NR4) ? (sum - NR4) : sum;
  assign pick  = sum_m[2:0];

  // Completion: real mem_ready wins over the timeout on the expiry cycle.
  logic busy, expire, done;
  assign busy   = (state == BUSY);
  assign expire = (TIMEOUT > 0) && busy && !mem_ready &&
                  (counter == CW'(TIMEOUT - 1));
  assign done   = busy && (mem_ready || expire);

  assign req_rdata   = expire ? TIMEOUT_RDATA : mem_rdata;
  assign timeout_err = expire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mem_rr_arbiter_lane #(.LANE(i)) u_lane (
      .grant (grant),
      .done  (done),
      .ready (req_ready[i])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      grant      <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      counter    <= '0;
      timeout_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick;
            mem_instr <= instr_a[pick];
            mem_addr  <= addr_a[pick];
            mem_wdata <= wdata_a[pick];
            mem_wstrb <= wstrb_a[pick];
            mem_valid <= 1'b1;
            counter   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            mem_valid  <= 1'b0;
            last_grant <= grant;
            counter    <= '0;
            state      <= IDLE;
            if (expire) timeout_id <= grant;
          end else if (TIMEOUT > 0) begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [NR-1:0]   req_valid, req_instr, req_ready;
  logic [32*NR-1:0] req_addr, req_wdata;
  logic [4*NR-1:0] req_wstrb;
  logic [31:0]     req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic            mem_valid, mem_instr, mem_ready, timeout_err;
  logic [3:0]      mem_wstrb;
  logic [2:0]      timeout_id;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err), .timeout_id(timeout_id)
  );

  typedef struct {
    int          id;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_exp_t;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          to;
  } resp_t;

  mem_exp_t expq[$];
  resp_t    respq[$];

  int tests = 0, errors = 0;
  bit run = 1'b0, issuing = 1'b0;
  int issued[NR], served[NR];

  logic [NR-1:0] vld_at_edge, rdy_at_edge;
  always @(posedge clk) begin
    vld_at_edge <= req_valid;
    rdy_at_edge <= req_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first pending requester after the last one served.
  function automatic int rr_pick(input logic [NR-1:0] pend, input int last);
    for (int k = 1; k <= NR; k++)
      if (pend[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Stimulus: requesters plus a memory model with random latency.
  // Expected downstream requests and upstream responses are queued here.
  initial begin : driver
    int m_last, bcyc, lat, g;
    logic [31:0] cur_rd;
    bit mv_prev;
    mem_exp_t e;
    resp_t r;
    m_last = NR - 1; bcyc = 0; lat = 0; cur_rd = '0; mv_prev = 1'b0;
    for (int i = 0; i < NR; i++) begin issued[i] = 0; served[i] = 0; end
    forever begin
      @(negedge clk);
      if (run) begin
        if (mem_valid && !mv_prev) begin
          g = rr_pick(vld_at_edge, m_last);
          tests++;
          if (g < 0) begin
            errors++;
            $display("FAIL grant_pending: mem_valid rose with pending %b", vld_at_edge);
            g = 0;
          end
          m_last  = g;
          e.id    = g;
          e.instr = req_instr[g];
          e.addr  = req_addr[32*g +: 32];
          e.wdata = req_wdata[32*g +: 32];
          e.wstrb = req_wstrb[4*g +: 4];
          expq.push_back(e);
          case ($urandom_range(0, 9))
            0, 1:    lat = TO + 1 + $urandom_range(0, 5);  // hang -> timeout
            2:       lat = TO;                             // ready on expiry cycle
            default: lat = $urandom_range(1, TO - 1);
          endcase
          cur_rd  = $urandom;
          r.id    = g;
          r.to    = (lat > TO);
          r.rdata = r.to ? 32'hDEAD_BEEF : cur_rd;
          respq.push_back(r);
          bcyc = 1;
        end else if (mem_valid) begin
          bcyc++;
        end
        mv_prev   = mem_valid;
        mem_ready = mem_valid && (bcyc == lat);
        mem_rdata = mem_ready ? cur_rd : $urandom;

        for (int i = 0; i < NR; i++) begin
          if (rdy_at_edge[i]) begin
            req_valid[i] = 1'b0;
            served[i]++;
          end
          if (!req_valid[i] && issuing && $urandom_range(0, 3) == 0) begin
            req_instr[i]         = 1'($urandom_range(0, 1));
            req_addr[32*i +: 32]  = $urandom;
            req_wdata[32*i +: 32] = $urandom;
            req_wstrb[4*i +: 4]   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            req_valid[i]         = 1'b1;
            issued[i]++;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request or response.
  initial begin : monitor
    mem_exp_t cur;
    resp_t r;
    bit chk_next, chk_to, mv_prev_m;
    int chk_id;
    chk_next = 1'b0; chk_to = 1'b0; mv_prev_m = 1'b0; chk_id = 0;
    forever begin
      @(negedge clk); #1;
      if (run) begin
        if (chk_next) begin
          chk("idle_after_done", 32'(mem_valid), 32'd0);
          if (chk_to) chk("timeout_id", 32'(timeout_id), 32'(chk_id));
          chk_next = 1'b0;
        end
        if (mem_valid && !mv_prev_m) begin
          tests++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: mem_valid with no expected request");
          end else begin
            cur = expq.pop_front();
            chk("mem_addr",  mem_addr,  cur.addr);
            chk("mem_wdata", mem_wdata, cur.wdata);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
            chk("mem_instr", 32'(mem_instr), 32'(cur.instr));
          end
        end else if (mem_valid) begin
          chk("mem_addr_stable", mem_addr, cur.addr);
        end
        if (req_ready != '0) begin
          tests++;
          if (respq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: req_ready=%b with no expected response", req_ready);
          end else begin
            r = respq.pop_front();
            chk("req_ready",   32'(req_ready), 32'(1 << r.id));
            chk("req_rdata",   req_rdata, r.rdata);
            chk("timeout_err", 32'(timeout_err), 32'(r.to));
            chk_next = 1'b1; chk_to = r.to; chk_id = r.id;
          end
        end else if (timeout_err) begin
          tests++; errors++;
          $display("FAIL timeout_err_spurious: got 1 expected 0 at %0t", $time);
        end
        mv_prev_m = mem_valid;
      end
    end
  end

  initial begin : main
    int n;
    resetn = 1'b0; req_valid = '0; req_instr = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid",   32'(mem_valid),   32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_timeout_id",  32'(timeout_id),  32'd0);
    chk("rst_mem_addr",    mem_addr,         32'd0);
    chk("rst_mem_wstrb",   32'(mem_wstrb),   32'd0);

    @(negedge clk);
    resetn = 1'b1;
    run = 1'b1; issuing = 1'b1;
    repeat (3000) @(negedge clk);
    issuing = 1'b0;

    n = 0;
    #2;
    while ((req_valid != '0 || mem_valid) && n < 400) begin
      @(negedge clk); #2;
      n++;
    end
    chk("drain_done", 32'(req_valid != '0 || mem_valid), 32'd0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    chk("expq_empty",  32'(expq.size()),  32'd0);
    chk("respq_empty", 32'(respq.size()), 32'd0);
    for (int i = 0; i < NR; i++) begin
      chk("served_eq_issued", 32'(served[i]), 32'(issued[i]));
      chk("served_nonzero",   32'(served[i] > 0), 32'd1);
    end

    // Reset while BUSY, then a single pending write on port 1.
    @(negedge clk);
    req_addr[31:0] = 32'h0000_0100; req_wstrb[3:0] = 4'h0; req_valid = 2'b01;
    mem_ready = 1'b0;
    n = 0;
    @(negedge clk); #1;
    while (!mem_valid && n < 5) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rb_busy", 32'(mem_valid), 32'd1);
    chk("rb_addr", mem_addr, 32'h0000_0100);
    #1 resetn = 1'b0;
    #1;
    chk("rb_async_drop",  32'(mem_valid), 32'd0);
    chk("rb_ready_quiet", 32'(req_ready), 32'd0);
    req_valid = 2'b10;
    req_addr[63:32] = 32'h2000_0000; req_wdata[63:32] = 32'd123456789; req_wstrb[7:4] = 4'hF;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("rb_grant1_valid", 32'(mem_valid), 32'd1);
    chk("rb_grant1_addr",  mem_addr,  32'h2000_0000);
    chk("rb_grant1_wdata", mem_wdata, 32'd123456789);
    chk("rb_grant1_wstrb", 32'(mem_wstrb), 32'hF);
    mem_rdata = 32'h1234_5678; mem_ready = 1'b1;
    #1;
    chk("rb_ready",  32'(req_ready), 32'b10);
    chk("rb_rdata",  req_rdata, 32'h1234_5678);
    chk("rb_no_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0; req_valid = '0;
    #1;
    chk("rb_idle", 32'(mem_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
